dec_1101_evt_logger: RTL

//   Downstream consumer of the 1101 sequence detector's registered dout pulse.

---
 rtl/dec_pkg.sv | 25 ++
 rtl/dec_evt_fifo.sv | 113 +++++++++++
 rtl/dec_1101_evt_logger.sv | 101 ++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared defaults and helpers for the 1101 detector family
//
// Purpose : default widths/depth for the 1101 detector event logger, a helper
//           that sizes FIFO occupancy outputs, and the FIFO operation encoding.
// Ports   : none (package)
package dec_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Occupancy runs 0..depth inclusive, so one bit more than the address.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Encoding is {push, pop} so the two qualified strobes cast directly.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/dec_evt_fifo.sv
// rtl/dec_evt_fifo.sv - synchronous show-ahead FIFO for detection timestamps
//
// Purpose : buffers WIDTH-bit entries, DEPTH deep (power of 2, >= 2). The head
//           entry is held in a register so dout is valid whenever empty=0 and
//           keeps its last value after the FIFO drains.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-low reset
//           clr   - synchronous clear, priority over push/pop
//           push  - write din (ignored when full unless popping the same cycle)
//           pop   - remove head entry (ignored when empty)
//           din   - entry to write
//           dout  - head entry
//           full  - DEPTH entries held
//           empty - no entries held
//           level - occupancy 0..DEPTH
module dec_evt_fifo
  import dec_pkg::*;
#(
  parameter int WIDTH = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [PW-1:0]    cnt_after_pop;
  logic [WIDTH-1:0] head_q;
  logic             pop_ok;
  logic             push_ok;
  fifo_op_e         op;

  // Pointers carry one wrap bit beyond the address: equal -> empty,
  // same address with differing wrap bit -> full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign op      = fifo_op_e'({push_ok, pop_ok});

  assign rd_ptr_nxt    = rd_ptr + PTR_ONE;
  assign cnt_after_pop = pop_ok ? (level - PTR_ONE) : level;

  assign dout = head_q;

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      head_q <= '0;
    end else if (clr) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      head_q <= '0;
    end else begin
      case (op)
        FIFO_PUSH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          // Only an empty FIFO takes its new head straight from din.
          if (empty) begin
            head_q <= din;
          end
        end
        FIFO_POP: begin
          rd_ptr <= rd_ptr_nxt;
          // Draining the last entry leaves head_q holding its old value.
          if (cnt_after_pop != PTR_ZERO) begin
            head_q <= mem[rd_ptr_nxt[AW-1:0]];
          end
        end
        FIFO_BOTH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr_nxt;
          // With a single entry the incoming word becomes the head; when full
          // the write lands in the slot being vacated, never the next head.
          if (cnt_after_pop == PTR_ZERO) begin
            head_q <= din;
          end else begin
            head_q <= mem[rd_ptr_nxt[AW-1:0]];
          end
        end
        FIFO_IDLE: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/dec_1101_evt_logger.sv
// rtl/dec_1101_evt_logger.sv - timestamps and buffers 1101 detector pulses
//
// Purpose : stamps every cycle det_in is high with a free-running cycle
//           counter, queues the stamps for a host on a valid/ready port, keeps
//           a saturating total-detection count and a sticky overflow flag.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-low reset
//           det_in    - detection pulse; each high cycle is one event
//           clr       - synchronous clear of all state, highest priority
//           out_valid - a stamp is available on out_data
//           out_ready - host takes out_data this cycle
//           out_data  - timestamp of the oldest buffered detection
//           level     - FIFO occupancy 0..DEPTH
//           evt_count - detections since reset/clr, saturating
//           overflow  - sticky: a detection was dropped on a full FIFO
module dec_1101_evt_logger
  import dec_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        det_in,
  input  logic                        clr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TS_W-1:0]             out_data,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic [CNT_W-1:0]            evt_count,
  output logic                        overflow
);

  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0] ts;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            can_push;
  logic            push;
  logic            drop;

  assign out_valid = ~fifo_empty;
  assign fifo_pop  = out_valid & out_ready;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign can_push = ~fifo_full | fifo_pop;
  assign push     = det_in & can_push;
  assign drop     = det_in & ~can_push;

  // The stamp pushed at an edge is the counter value before that edge's
  // increment, i.e. the value visible during the cycle det_in was high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts <= '0;
    end else if (clr) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_count <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      // Dropped events still count as detections.
      if (det_in && (evt_count != CNT_MAX)) begin
        evt_count <= evt_count + CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  dec_evt_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (fifo_pop),
    .din   (ts),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule
